spi_slave_rx: RTL and testbench
===============================

SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

Interface
REQ-001 Parameter DATA_W, default 16: word length in bits.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer flops on each SPI input, minimum 2.
REQ-003 Reset is rst, asynchronous, active-high; clock is clk.
REQ-004 clk  input  1  system clock; all outputs are registered on its rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 spi_mclk  input  1  SPI serial clock from the master; idles low.
REQ-007 spi_dat  input  1  serial data from the master, MSB first.
REQ-008 spi_ssal  input  1  slave select, active low.
REQ-009 rx_data  output  DATA_W  last completed word.
REQ-010 rx_valid  output  1  rx_data holds an unconsumed word.
REQ-011 rx_ready  input  1  consumer accepts the word when rx_valid && rx_ready.
REQ-012 rx_overrun  output  1  one-cycle pulse: a completed word was dropped.
REQ-013 bit_count  output  5  bits remaining in the current word.
REQ-014 frame_err  output  1  one-cycle pulse: the frame was aborted mid-word (exists only when SPI_RX_FRAME_ERR_EN is defined).

Function
REQ-015 spi_mclk, spi_dat and spi_ssal SHALL pass through identical SYNC_STAGES flop chains, so data stays aligned with the clock edge.
REQ-016 A sampling edge SHALL be a synchronized spi_mclk transition from 0 to 1, detected with one extra flop.
REQ-017 FSM IDLE: synchronized ssal is high, the shifter is held and bit_count = DATA_W; on synchronized ssal low, go to SHIFT.
REQ-018 FSM SHIFT: on each sampling edge, shift = {shift[DATA_W-2:0], dat_sync} and bit_count decrements by 1.
REQ-019 In SHIFT, if bit_count reaches 0 on an edge, go to DONE; if synchronized ssal goes high first, reload bit_count = DATA_W, discard the partial word and go to IDLE.
REQ-020 FSM DONE lasts one clk: bit_count reloads to DATA_W; next state is SHIFT if synchronized ssal is low, otherwise IDLE.
REQ-021 Completion SHALL be tolerated with the master's minimum framing: clk-rate spi_mclk (1 clk high, 1 clk low) and ssal high for only 1 clk between words.
REQ-022 When a word completes and rx_valid = 0, or rx_valid && rx_ready in the same cycle, rx_data SHALL load the word and rx_valid SHALL assert one clk after entering DONE.
REQ-023 When a word completes while rx_valid && !rx_ready, the new word SHALL be dropped, rx_data SHALL be unchanged, and rx_overrun SHALL pulse for one clk.
REQ-024 rx_valid SHALL clear on the clk after rx_valid && rx_ready, unless a simultaneous completion reloads it (REQ-022).
REQ-025 Latency SHALL be at most SYNC_STAGES+3 clk from the 16th raw spi_mclk rising edge to rx_valid high.
REQ-026 Sampling edges occurring while in IDLE SHALL be ignored.
REQ-027 bit_count width SHALL be 5 bits, saturating at range 0..DATA_W, with no wrap below 0.

Reset
REQ-028 On rst, outputs SHALL be: rx_data = 0, rx_valid = 0, rx_overrun = 0, bit_count = DATA_W, frame_err = 0.
REQ-029 On rst, the FSM SHALL go to IDLE, and the shifter and synchronizers SHALL clear (spi_ssal chain to 1, others to 0).
REQ-030 Reset asserted mid-word SHALL discard the partial word; after release, reception SHALL restart only on the next ssal-low-to-edge sequence.

Configuration
REQ-031 Macro SPI_RX_FRAME_ERR_EN controls abort reporting.
REQ-032 With SPI_RX_FRAME_ERR_EN defined: the frame_err port exists, and it pulses for 1 clk when ssal deasserts in SHIFT with 0 < bit_count < DATA_W.
REQ-033 Without SPI_RX_FRAME_ERR_EN: the frame_err port is absent and aborts are silent; all other behaviour is identical.

Verification
REQ-034 Frame 0xA5C3, rx_ready held 1 -> rx_data = 0xA5C3, rx_valid high for 1 clk, bit_count sequence 16,15,...,0,16.
REQ-035 Back-to-back frames 0x0001 then 0x8000 with 1-clk ssal gap, rx_ready = 1 -> two valid words with values in order, no overrun.
REQ-036 rx_ready = 0, frames 0x1234 then 0xFFFF -> rx_data stays 0x1234, rx_overrun pulses once; rx_ready = 1 then clears rx_valid.
REQ-037 ssal raised after 7 bits, then full frame 0x00FF -> no rx_valid for the partial word, rx_data = 0x00FF; frame_err pulses once only when the macro is defined.
REQ-038 rst pulsed after 9 bits of 0xBEEF, then full frame 0x5A5A -> all outputs at reset values, next word 0x5A5A.

Source files
------------

// File: rtl/spi_slave_rx.sv
// spi_slave_rx: SPI slave receiver. spi_mclk, spi_dat and spi_ssal are
// synchronized into the clk domain, words are shifted in MSB first on
// rising spi_mclk edges, and each completed word is offered on a
// valid/ready output with overrun reporting. Defining the optional macro
// SPI_RX_FRAME_ERR_EN adds a frame_err pulse that reports words aborted
// part-way through.
module spi_slave_rx #(
   parameter int DATA_W      = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              spi_mclk,
   input  logic              spi_dat,
   input  logic              spi_ssal,
   input  logic              rx_ready,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              rx_overrun,
   output logic [4:0]        bit_count
`ifdef SPI_RX_FRAME_ERR_EN
   ,
   output logic              frame_err
`endif
);

   localparam logic [4:0] FULL_COUNT = 5'(DATA_W);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t              r_state;
   logic [SYNC_STAGES-1:0] r_mclkSync;
   logic [SYNC_STAGES-1:0] r_datSync;
   logic [SYNC_STAGES-1:0] r_ssalSync;
   logic                r_mclkPrev;
   logic [DATA_W-1:0]   r_shift;

   logic w_mclk;
   logic w_dat;
   logic w_ssal;
   logic w_edge;

   assign w_mclk = r_mclkSync[SYNC_STAGES-1];
   assign w_dat  = r_datSync[SYNC_STAGES-1];
   assign w_ssal = r_ssalSync[SYNC_STAGES-1];
   assign w_edge = w_mclk & ~r_mclkPrev;

   // Equal-length synchronizer chains keep data and select aligned with the
   // serial clock; one extra flop on the clock chain detects its rising edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mclkSync <= '0;
         r_datSync  <= '0;
         r_ssalSync <= '1;
         r_mclkPrev <= 1'b0;
      end else begin
         r_mclkSync <= {r_mclkSync[SYNC_STAGES-2:0], spi_mclk};
         r_datSync  <= {r_datSync[SYNC_STAGES-2:0], spi_dat};
         r_ssalSync <= {r_ssalSync[SYNC_STAGES-2:0], spi_ssal};
         r_mclkPrev <= w_mclk;
      end
   end

   // Receive FSM with its registered outputs: shifting, bit counting, word
   // hand-off to the consumer, overrun and abort pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_shift    <= '0;
         bit_count  <= FULL_COUNT;
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         rx_overrun <= 1'b0;
`ifdef SPI_RX_FRAME_ERR_EN
         frame_err  <= 1'b0;
`endif
      end else begin
         rx_overrun <= 1'b0;
`ifdef SPI_RX_FRAME_ERR_EN
         frame_err  <= 1'b0;
`endif
         if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
         case (r_state)
            IDLE: begin
               bit_count <= FULL_COUNT;
               if (!w_ssal) begin
                  r_state <= SHIFT;
               end
            end
            SHIFT: begin
               if (w_ssal) begin
                  r_state   <= IDLE;
                  bit_count <= FULL_COUNT;
                  r_shift   <= '0;
`ifdef SPI_RX_FRAME_ERR_EN
                  if ((bit_count != FULL_COUNT) && (bit_count != 5'd0)) begin
                     frame_err <= 1'b1;
                  end
`endif
               end else if (w_edge) begin
                  r_shift <= {r_shift[DATA_W-2:0], w_dat};
                  if (bit_count != 5'd0) begin
                     bit_count <= bit_count - 5'd1;
                  end
                  if (bit_count == 5'd1) begin
                     r_state <= DONE;
                  end
               end
            end
            DONE: begin
               bit_count <= FULL_COUNT;
               r_state   <= w_ssal ? IDLE : SHIFT;
               if (!rx_valid || rx_ready) begin
                  rx_data  <= r_shift;
                  rx_valid <= 1'b1;
               end else begin
                  rx_overrun <= 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_slave_rx.sv
// tb_spi_slave_rx: directed and randomized frames for spi_slave_rx, checked
// against a transaction-level model of the receive buffer (one held word,
// accepted-word queue, overrun and abort counters).
module tb_spi_slave_rx;

   localparam int DATA_W = 16;
   localparam int SYNC   = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        spi_mclk;
   logic        spi_dat;
   logic        spi_ssal;
   logic        rx_ready;
   logic [15:0] rx_data;
   logic        rx_valid;
   logic        rx_overrun;
   logic [4:0]  bit_count;
`ifdef SPI_RX_FRAME_ERR_EN
   logic        frame_err;
`endif

   int compared   = 0;
   int mismatched = 0;

   logic [15:0] gotQ[$];
   logic [15:0] expQ[$];
   logic [4:0]  bcQ[$];
   logic [4:0]  lastBc;
   bit          recordBc = 1'b0;
   int          ovCnt = 0;
   int          ovExp = 0;
   int          feCnt = 0;
   int          feExp = 0;
   bit          mValid;
   logic [15:0] mData;

   // Free-running system clock
   always #5 clk = ~clk;

   spi_slave_rx #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC)) dut (
      .clk        (clk),
      .rst        (rst),
      .spi_mclk   (spi_mclk),
      .spi_dat    (spi_dat),
      .spi_ssal   (spi_ssal),
      .rx_ready   (rx_ready),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_overrun (rx_overrun),
      .bit_count  (bit_count)
`ifdef SPI_RX_FRAME_ERR_EN
      ,
      .frame_err  (frame_err)
`endif
   );

   // Observe accepted words, pulses and bit_count changes away from the edge
   always @(negedge clk) begin
      if (!rst) begin
         if (rx_valid && rx_ready) gotQ.push_back(rx_data);
         if (rx_overrun) ovCnt++;
`ifdef SPI_RX_FRAME_ERR_EN
         if (frame_err) feCnt++;
`endif
         if (recordBc && (bit_count !== lastBc)) begin
            bcQ.push_back(bit_count);
            lastBc = bit_count;
         end
      end
   end

   // Give up on a hung run
   initial begin
      #5_000_000;
      $display("[TB] FAIL timeout: simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      assert (got === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Serial driver: ssal low, then per bit one clk low and one clk high
   task automatic applyStimulus(input logic [15:0] w, input int nbits, input bit raise);
      spi_ssal = 1'b0;
      for (int i = 0; i < nbits; i++) begin
         spi_dat  = w[15-i];
         spi_mclk = 1'b0;
         tick();
         spi_mclk = 1'b1;
         tick();
      end
      spi_mclk = 1'b0;
      if (raise) begin
         spi_ssal = 1'b1;
         tick();
      end
   endtask

   // Model: a completed word with the current ready level
   task automatic modelWord(input logic [15:0] w);
      if (rx_ready) begin
         expQ.push_back(w);
         mData = w;
      end else if (!mValid) begin
         mValid = 1'b1;
         mData  = w;
      end else begin
         ovExp++;
      end
   endtask

   task automatic sendFrame(input logic [15:0] w, input int nbits);
      applyStimulus(w, nbits, 1'b1);
      if (nbits == 16) modelWord(w);
      else if (nbits > 0) feExp++;
   endtask

   task automatic setReady(input bit r);
      if (r && !rx_ready && mValid) begin
         expQ.push_back(mData);
         mValid = 1'b0;
      end
      rx_ready = r;
   endtask

   task automatic compareQueues(input string tag);
      checkOutput({tag, "_count"}, 32'(gotQ.size()), 32'(expQ.size()));
      for (int i = 0; i < gotQ.size() && i < expQ.size(); i++)
         checkOutput({tag, "_word"}, 32'(gotQ[i]), 32'(expQ[i]));
      gotQ.delete();
      expQ.delete();
   endtask

   task automatic checkState(input string tag);
      checkOutput({tag, "_rx_data"}, 32'(rx_data), 32'(mData));
      checkOutput({tag, "_rx_valid"}, 32'(rx_valid), 32'(mValid));
      checkOutput({tag, "_overruns"}, 32'(ovCnt), 32'(ovExp));
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_rx_data"}, 32'(rx_data), 32'h0);
      checkOutput({tag, "_rx_valid"}, 32'(rx_valid), 32'h0);
      checkOutput({tag, "_rx_overrun"}, 32'(rx_overrun), 32'h0);
      checkOutput({tag, "_bit_count"}, 32'(bit_count), 32'd16);
   endtask

   // Directed scenarios followed by randomized traffic
   initial begin
      int   lat;
      bit   seen;
      logic [15:0] w;
      int   nbits;
      int   nfr;

      rst = 1'b1; spi_mclk = 1'b0; spi_dat = 1'b0; spi_ssal = 1'b1; rx_ready = 1'b1;
      mValid = 1'b0; mData = 16'h0;
      tick(3);
      checkResetValues("in_reset");
      rst = 1'b0;
      tick(2);
      checkResetValues("after_reset");

      // Single frame: bit_count trace and completion latency
      recordBc = 1'b1;
      lastBc   = 5'd16;
      bcQ.push_back(5'd16);
      applyStimulus(16'hA5C3, 16, 1'b0);
      lat  = 1;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         if (rx_valid) seen = 1'b1;
         else begin
            @(posedge clk);
            lat++;
         end
      end
      checkOutput("latency_valid_seen", 32'(seen), 32'h1);
      checkOutput("latency_bound", 32'(lat <= SYNC + 3), 32'h1);
      #1;
      spi_ssal = 1'b1;
      tick();
      modelWord(16'hA5C3);
      tick(6);
      recordBc = 1'b0;
      checkOutput("bc_trace_len", 32'(bcQ.size()), 32'd18);
      for (int i = 0; i < bcQ.size() && i < 18; i++)
         checkOutput("bc_trace", 32'(bcQ[i]), (i < 17) ? 32'(16 - i) : 32'd16);
      compareQueues("a5c3");
      checkState("a5c3");

      // Back-to-back with minimal gap
      sendFrame(16'h0001, 16);
      sendFrame(16'h8000, 16);
      tick(8);
      compareQueues("b2b");
      checkState("b2b");

      // Overrun with consumer stalled, then drain
      setReady(1'b0);
      tick();
      sendFrame(16'h1234, 16);
      sendFrame(16'hFFFF, 16);
      tick(8);
      checkState("overrun");
      setReady(1'b1);
      tick(3);
      checkState("drain");
      compareQueues("drain");

      // Aborted partial word followed by a full one
      sendFrame(16'h6B3D, 7);
      sendFrame(16'h00FF, 16);
      tick(8);
      compareQueues("abort");
      checkState("abort");
`ifdef SPI_RX_FRAME_ERR_EN
      checkOutput("abort_frame_err", 32'(feCnt), 32'(feExp));
`endif

      // Reset in the middle of a word
      applyStimulus(16'hBEEF, 9, 1'b0);
      spi_ssal = 1'b1;
      rst = 1'b1;
      tick(2);
      checkResetValues("mid_reset");
      rst = 1'b0;
      mValid = 1'b0;
      mData  = 16'h0;
      tick(2);
      checkResetValues("post_reset");
      sendFrame(16'h5A5A, 16);
      tick(8);
      compareQueues("post_reset");
      checkState("post_reset");

      // Randomized frames, lengths and consumer readiness
      for (int it = 0; it < 40; it++) begin
         setReady(1'($urandom_range(0, 1)));
         tick(2);
         nfr = $urandom_range(1, 3);
         for (int f = 0; f < nfr; f++) begin
            w     = 16'($urandom);
            nbits = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 15) : 16;
            sendFrame(w, nbits);
         end
         tick(8);
         checkState("rand");
         compareQueues("rand");
      end
      setReady(1'b1);
      tick(3);
      checkState("final");
      compareQueues("final");
`ifdef SPI_RX_FRAME_ERR_EN
      checkOutput("final_frame_err", 32'(feCnt), 32'(feExp));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
